i2c_master_read_byte_ctrl: RTL and testbench

- Master-side controller that sequences one full I2C read byte: 8 data bit slots, MSB first, followed by one ACK/NACK slot driven by the master.
- Generates SCL, samples SDA with glitch detection, and drives the open-drain SDA enable for the acknowledge.
- Sits between the byte-level transaction FSM (go/finish handshake) and the pad open-drain logic.

---
 rtl/i2c_pkg.sv | 17 +
 rtl/i2c_bit_phase_gen.sv | 53 +++++
 rtl/i2c_master_read_byte_ctrl.sv | 160 ++++++++++++++++
 tb/tb_i2c_master_read_byte_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C byte-level controllers.
// Bit slots are 8 phases: SCL low for phases 0-3, high for phases 4-7.
package i2c_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      ACK,
      DONE
   } state_e;

   localparam int PHASES_PER_BIT       = 8;
   localparam int SCL_HIGH_FIRST_PHASE = 4;
   localparam int BITS_PER_BYTE        = 8;
   localparam int SAMPLES_PER_BIT      = 4;

endpackage

// File: rtl/i2c_bit_phase_gen.sv
// Prescaler plus 3-bit phase counter for one I2C bit slot.
// Shared by the read-byte and write-byte controllers.
module i2c_bit_phase_gen
   import i2c_pkg::*;
#(
   parameter int PHASE_CYCLES = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       en,
   input  logic       clr,
   output logic [2:0] phase,
   output logic [2:0] phase_nxt,
   output logic       phase_last_clk,
   output logic       slot_end
);

   localparam logic [7:0] PRESC_MAX = 8'(PHASE_CYCLES - 1);
   localparam logic [2:0] PHASE_MAX = 3'(PHASES_PER_BIT - 1);

   logic [7:0] presc_q, presc_d;
   logic [2:0] phase_q, phase_d;

   always_comb begin
      presc_d        = presc_q;
      phase_d        = phase_q;
      phase_last_clk = en && (presc_q == PRESC_MAX);
      slot_end       = phase_last_clk && (phase_q == PHASE_MAX);
      if (clr) begin
         presc_d = '0;
         phase_d = '0;
      end else if (phase_last_clk) begin
         presc_d = '0;
         phase_d = phase_q + 3'd1;
      end else if (en) begin
         presc_d = presc_q + 8'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         presc_q <= '0;
         phase_q <= '0;
      end else begin
         presc_q <= presc_d;
         phase_q <= phase_d;
      end
   end

   assign phase     = phase_q;
   assign phase_nxt = phase_d;

endmodule

// File: rtl/i2c_master_read_byte_ctrl.sv
// Master-side I2C read of one byte: 8 sampled data slots then a
// master-driven ACK/NACK slot, with glitch detection on SDA.
module i2c_master_read_byte_ctrl
   import i2c_pkg::*;
#(
   parameter int PHASE_CYCLES = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       go,
   input  logic       ack_en,
   input  logic       sda_in,
   output logic       scl,
   output logic       sda_oe,
   output logic [7:0] data,
   output logic       finish,
   output logic       error
);

   state_e     state_q, state_d;
   logic [2:0] slot_q, slot_d;
   logic [2:0] ones_q, ones_d;
   logic [7:0] shift_q, shift_d;
   logic       err_q, err_d;
   logic       ack_lat_q, ack_lat_d;
   logic       scl_q, scl_d;
   logic       sda_oe_q, sda_oe_d;
   logic [7:0] data_q, data_d;
   logic       finish_q, finish_d;
   logic       error_q, error_d;

   logic       en, clr;
   logic [2:0] phase, phase_nxt;
   logic       phase_last_clk, slot_end;
   logic [2:0] ones_all;
   logic       bit_val, bit_mixed, busy_d;

   i2c_bit_phase_gen #(
      .PHASE_CYCLES(PHASE_CYCLES)
   ) u_phase (
      .clock         (clock),
      .reset         (reset),
      .en            (en),
      .clr           (clr),
      .phase         (phase),
      .phase_nxt     (phase_nxt),
      .phase_last_clk(phase_last_clk),
      .slot_end      (slot_end)
   );

   // ones_all folds in the phase-7 sample taken on the slot's last clock
   assign ones_all  = ones_q + {2'b00, sda_in};
   assign bit_val   = (ones_all == 3'(SAMPLES_PER_BIT));
   assign bit_mixed = (ones_all != 3'd0) && !bit_val;

   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      ones_d    = ones_q;
      shift_d   = shift_q;
      err_d     = err_q;
      ack_lat_d = ack_lat_q;
      data_d    = data_q;
      error_d   = error_q;
      en        = 1'b0;
      clr       = 1'b0;
      unique case (state_q)
         IDLE: begin
            clr = 1'b1;
            if (go) begin
               state_d   = READ;
               slot_d    = 3'(BITS_PER_BYTE - 1);
               ack_lat_d = ack_en;
               shift_d   = '0;
               err_d     = 1'b0;
               ones_d    = '0;
            end
         end
         READ: begin
            en = 1'b1;
            if (phase_last_clk && phase >= 3'(SCL_HIGH_FIRST_PHASE))
               ones_d = ones_all;
            if (slot_end) begin
               clr     = 1'b1;
               ones_d  = '0;
               shift_d = {shift_q[6:0], bit_val};
               if (bit_mixed)
                  err_d = 1'b1;
               if (slot_q == 3'd0)
                  state_d = ACK;
               else
                  slot_d = slot_q - 3'd1;
            end
         end
         ACK: begin
            en = 1'b1;
            if (slot_end) begin
               clr     = 1'b1;
               state_d = DONE;
               data_d  = shift_q;
               error_d = err_q;
            end
         end
         DONE: begin
            if (!go)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Abort mid-byte: drop everything collected so far
      if (!go && (state_q == READ || state_q == ACK)) begin
         state_d = IDLE;
         clr     = 1'b1;
         shift_d = '0;
         err_d   = 1'b0;
         ones_d  = '0;
         data_d  = data_q;
         error_d = error_q;
      end
      busy_d   = (state_d == READ) || (state_d == ACK);
      scl_d    = !busy_d || (phase_nxt >= 3'(SCL_HIGH_FIRST_PHASE));
      sda_oe_d = (state_d == ACK) && ack_lat_q;
      finish_d = (state_d == DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         slot_q    <= '0;
         ones_q    <= '0;
         shift_q   <= '0;
         err_q     <= 1'b0;
         ack_lat_q <= 1'b0;
         scl_q     <= 1'b1;
         sda_oe_q  <= 1'b0;
         data_q    <= '0;
         finish_q  <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         slot_q    <= slot_d;
         ones_q    <= ones_d;
         shift_q   <= shift_d;
         err_q     <= err_d;
         ack_lat_q <= ack_lat_d;
         scl_q     <= scl_d;
         sda_oe_q  <= sda_oe_d;
         data_q    <= data_d;
         finish_q  <= finish_d;
         error_q   <= error_d;
      end
   end

   assign scl    = scl_q;
   assign sda_oe = sda_oe_q;
   assign data   = data_q;
   assign finish = finish_q;
   assign error  = error_q;

endmodule

// File: tb/tb_i2c_master_read_byte_ctrl.sv
// Bench for the I2C read-byte controller at PHASE_CYCLES=1 and 4.
module tb_i2c_master_read_byte_ctrl;

   logic       clock = 1'b0;
   logic       rst1, go1, ack1, sda1;
   logic       scl1, oe1, fin1, err1;
   logic [7:0] data1;
   logic       rst4, go4, ack4, sda4;
   logic       scl4, oe4, fin4, err4;
   logic [7:0] data4;

   always #5 clock = ~clock;

   i2c_master_read_byte_ctrl #(.PHASE_CYCLES(1)) dut1 (
      .clock(clock), .reset(rst1), .go(go1), .ack_en(ack1),
      .sda_in(sda1), .scl(scl1), .sda_oe(oe1), .data(data1),
      .finish(fin1), .error(err1)
   );

   i2c_master_read_byte_ctrl #(.PHASE_CYCLES(4)) dut4 (
      .clock(clock), .reset(rst4), .go(go4), .ack_en(ack4),
      .sda_in(sda4), .scl(scl4), .sda_oe(oe4), .data(data4),
      .finish(fin4), .error(err4)
   );

   typedef struct {
      int         p;
      logic [7:0] tx;
      logic       ack;
      int         gbit;
      logic [7:0] exp_d;
      logic       exp_e;
   } vec_t;

   typedef struct {
      logic [7:0] d;
      logic       e;
   } sb_t;

   sb_t  sb[$];
   vec_t vecs[5];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input int p, input logic r, input logic g,
                        input logic a, input logic s);
      if (p == 1) begin
         rst1 = r; go1 = g; ack1 = a; sda1 = s;
      end else begin
         rst4 = r; go4 = g; ack4 = a; sda4 = s;
      end
   endtask

   // {scl, sda_oe, finish, error, data}
   function automatic logic [11:0] outs(input int p);
      if (p == 1)
         return {scl1, oe1, fin1, err1, data1};
      return {scl4, oe4, fin4, err4, data4};
   endfunction

   // abort_c>0 aborts at that cycle: rst_mode=1 via reset, else via go low
   task automatic run_byte(input int p, input logic [7:0] tx,
                           input logic ack, input int gbit,
                           input logic [7:0] exp_d, input logic exp_e,
                           input int abort_c, input logic rst_mode);
      int          n;
      int          s, ph;
      int          bad_scl, bad_oe, bad_fin;
      logic        sd;
      logic [11:0] o;
      sb_t         e;
      n = 72 * p;
      bad_scl = 0; bad_oe = 0; bad_fin = 0;
      sd = 1'b1;
      if (abort_c == 0)
         sb.push_back('{d: exp_d, e: exp_e});
      drive(p, 1'b0, 1'b1, ack, 1'b1);
      step();
      for (int c = 1; c <= n; c++) begin
         o  = outs(p);
         s  = (c - 1) / (8 * p);
         ph = ((c - 1) % (8 * p)) / p;
         if (o[11] !== (ph >= 4)) bad_scl++;
         if (o[10] !== (s == 8 && ack)) bad_oe++;
         if (o[9] !== 1'b0) bad_fin++;
         if (c == abort_c) begin
            chk("pre_abort_scl", 32'(bad_scl), 0);
            chk("pre_abort_oe", 32'(bad_oe), 0);
            drive(p, rst_mode, 1'b0, ack, sd);
            step();
            o = outs(p);
            chk("abort_scl", 32'(o[11]), 1);
            chk("abort_oe", 32'(o[10]), 0);
            chk("abort_fin", 32'(o[9]), 0);
            chk("abort_err", 32'(o[8]), 32'(exp_e));
            chk("abort_data", 32'(o[7:0]), 32'(exp_d));
            drive(p, 1'b0, 1'b0, ack, 1'b1);
            bad_fin = 0;
            for (int k = 0; k < 10; k++) begin
               step();
               o = outs(p);
               if (o[9] !== 1'b0) bad_fin++;
            end
            chk("abort_no_fin", 32'(bad_fin), 0);
            return;
         end
         sd = (s < 8) ? tx[7 - s] : 1'b1;
         if (gbit >= 0 && s == 7 - gbit && ph == 5 && (c - 1) % p == 0)
            sd = 1'b0;
         drive(p, 1'b0, 1'b1, ack, sd);
         step();
      end
      chk("scl_shape", 32'(bad_scl), 0);
      chk("oe_window", 32'(bad_oe), 0);
      chk("no_early_fin", 32'(bad_fin), 0);
      o = outs(p);
      chk("finish_time", 32'(o[9]), 1);
      chk("done_scl", 32'(o[11]), 1);
      if (sb.size() == 0) begin
         chk("sb_nonempty", 0, 1);
      end else begin
         e = sb.pop_front();
         chk("data", 32'(o[7:0]), 32'(e.d));
         chk("error", 32'(o[8]), 32'(e.e));
      end
   endtask

   task automatic finish_handshake(input int p, input logic [7:0] exp_d,
                                   input logic exp_e);
      logic [11:0] o;
      int          bad;
      bad = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         o = outs(p);
         if (o[9] !== 1'b1 || o[7:0] !== exp_d || o[8] !== exp_e) bad++;
      end
      chk("done_hold", 32'(bad), 0);
      drive(p, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      o = outs(p);
      chk("fin_drop", 32'(o[9]), 0);
      chk("idle_data", 32'(o[7:0]), 32'(exp_d));
      chk("idle_err", 32'(o[8]), 32'(exp_e));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [11:0] o;
      vecs[0] = '{p: 1, tx: 8'hA5, ack: 1'b1, gbit: -1, exp_d: 8'hA5, exp_e: 1'b0};
      vecs[1] = '{p: 1, tx: 8'h3C, ack: 1'b1, gbit: 3,  exp_d: 8'h34, exp_e: 1'b1};
      vecs[2] = '{p: 1, tx: 8'hFF, ack: 1'b0, gbit: -1, exp_d: 8'hFF, exp_e: 1'b0};
      vecs[3] = '{p: 1, tx: 8'h5A, ack: 1'b1, gbit: -1, exp_d: 8'h5A, exp_e: 1'b0};
      vecs[4] = '{p: 4, tx: 8'h81, ack: 1'b1, gbit: -1, exp_d: 8'h81, exp_e: 1'b0};

      drive(1, 1'b1, 1'b0, 1'b0, 1'b1);
      drive(4, 1'b1, 1'b0, 1'b0, 1'b1);
      step();
      step();
      drive(1, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(4, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      for (int p = 1; p <= 4; p += 3) begin
         o = outs(p);
         chk("rst_scl", 32'(o[11]), 1);
         chk("rst_oe", 32'(o[10]), 0);
         chk("rst_fin", 32'(o[9]), 0);
         chk("rst_err", 32'(o[8]), 0);
         chk("rst_data", 32'(o[7:0]), 0);
      end

      for (int i = 0; i < 5; i++) begin
         run_byte(vecs[i].p, vecs[i].tx, vecs[i].ack, vecs[i].gbit,
                  vecs[i].exp_d, vecs[i].exp_e, 0, 1'b0);
         finish_handshake(vecs[i].p, vecs[i].exp_d, vecs[i].exp_e);
      end

      // go dropped during bit 4 keeps the previous 0x5A result
      run_byte(1, 8'hC3, 1'b1, -1, 8'h5A, 1'b0, 28, 1'b0);

      // reset pulsed in the ACK slot, then a clean byte
      run_byte(1, 8'hE7, 1'b1, -1, 8'h00, 1'b0, 66, 1'b1);
      run_byte(1, 8'h96, 1'b1, -1, 8'h96, 1'b0, 0, 1'b0);
      finish_handshake(1, 8'h96, 1'b0);

      chk("sb_drained", 32'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
